// File: rtl/row_streamer.sv
// Row streamer: buffers a FEATURE_ROWS x COLS matrix and streams one row per cycle to the argmax stage.
// Optional feature macro ROW_SYNC_CHECK_EN adds the consumer row-alignment check (sync_err).
module row_streamer #(
    parameter int unsigned FEATURE_ROWS   = 6,
    parameter int unsigned COLS           = 3,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ROW_ADDR_WIDTH = 3,
    parameter int unsigned COL_ADDR_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [ROW_ADDR_WIDTH-1:0] wr_row,
    input  logic [COL_ADDR_WIDTH-1:0] wr_col,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      start,
    input  logic [ROW_ADDR_WIDTH-1:0] consumer_row,
    input  logic                      argmax_done,
    output logic                      done_comb,
    output logic [DATA_WIDTH-1:0]     fm_wm_adj_out [0:COLS-1],
    output logic [ROW_ADDR_WIDTH-1:0] stream_row,
    output logic                      busy,
    output logic                      sync_err
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT_DONE
    } state_t;

    localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(FEATURE_ROWS - 1);

    state_t                    state;
    state_t                    state_next;
    logic [ROW_ADDR_WIDTH-1:0] row_cnt;
    logic [ROW_ADDR_WIDTH-1:0] row_cnt_next;
    logic [DATA_WIDTH-1:0]     buffer [0:FEATURE_ROWS-1][0:COLS-1];
    logic                      wr_ok;

    // Writes land only while idle and inside the matrix; a start in the same cycle does not block them.
    assign wr_ok = (state == IDLE) && wr_en &&
                   (32'(wr_row) < FEATURE_ROWS) && (32'(wr_col) < COLS);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < FEATURE_ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    buffer[r][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            buffer[wr_row][wr_col] <= wr_data;
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < COLS; c++) begin
            fm_wm_adj_out[c] = buffer[row_cnt][c];
        end
    end

    assign stream_row = row_cnt;

    always_comb begin
        state_next   = state;
        row_cnt_next = row_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = STREAM;
                    row_cnt_next = '0;
                end
            end
            STREAM: begin
                if (row_cnt == LAST_ROW) begin
                    state_next   = WAIT_DONE;
                    row_cnt_next = '0;
                end else begin
                    row_cnt_next = row_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (argmax_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                row_cnt_next = '0;
            end
        endcase
    end

    // done_comb and busy are flopped from the next state so they line up with state and row_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_cnt   <= '0;
            done_comb <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            row_cnt   <= row_cnt_next;
            done_comb <= (state_next == STREAM);
            busy      <= (state_next != IDLE);
        end
    end

`ifdef ROW_SYNC_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err <= 1'b0;
        end else if ((state == IDLE) && start) begin
            sync_err <= 1'b0;
        end else if ((state == STREAM) && (consumer_row != row_cnt)) begin
            sync_err <= 1'b1;
        end
    end
`else
    logic unused_consumer_row;

    assign unused_consumer_row = ^consumer_row;
    assign sync_err            = 1'b0;
`endif

endmodule

// File: tb/tb_row_streamer.sv
// Directed self-checking bench for row_streamer with a small consumer model (row counter + done).
// Expectations for sync_err follow ROW_SYNC_CHECK_EN.
module tb_row_streamer;

`ifdef ROW_SYNC_CHECK_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_row;
    logic [1:0]  wr_col;
    logic [15:0] wr_data;
    logic        start;
    logic [2:0]  consumer_row;
    logic        argmax_done;
    logic        done_comb;
    logic [15:0] fm_wm_adj_out [0:2];
    logic [2:0]  stream_row;
    logic        busy;
    logic        sync_err;

    logic        loopback;
    logic        man_done;
    logic        sync_ovr;
    logic [2:0]  cons_cnt;
    logic        cons_done;
    int          dc_count;
    int          errors;
    int          checks;
    logic [15:0] mdl [0:5][0:2];

    always #5 clk = ~clk;

    row_streamer #(
        .FEATURE_ROWS  (6),
        .COLS          (3),
        .DATA_WIDTH    (16),
        .ROW_ADDR_WIDTH(3),
        .COL_ADDR_WIDTH(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_row       (wr_row),
        .wr_col       (wr_col),
        .wr_data      (wr_data),
        .start        (start),
        .consumer_row (consumer_row),
        .argmax_done  (argmax_done),
        .done_comb    (done_comb),
        .fm_wm_adj_out(fm_wm_adj_out),
        .stream_row   (stream_row),
        .busy         (busy),
        .sync_err     (sync_err)
    );

    // Consumer: current_row counts sampled rows and clears on a low done_comb; done follows the last row.
    always_ff @(posedge clk) begin
        if (rst) begin
            cons_cnt  <= '0;
            cons_done <= 1'b0;
        end else begin
            cons_cnt  <= done_comb ? 3'(cons_cnt + 3'd1) : 3'd0;
            cons_done <= done_comb && (cons_cnt == 3'd5);
        end
    end

    always_ff @(posedge clk) begin
        if (done_comb) dc_count <= dc_count + 1;
    end

    assign consumer_row = sync_ovr ? 3'd3 : cons_cnt;
    assign argmax_done  = loopback ? cons_done : man_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int r, input int c, input logic [15:0] d, input bit accept);
        logic [31:0] rv;
        logic [31:0] cv;
        rv      = r;
        cv      = c;
        wr_en   = 1'b1;
        wr_row  = rv[2:0];
        wr_col  = cv[1:0];
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        if (accept) mdl[r][c] = d;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_row(input int k);
        check($sformatf("p%0d_done_comb", k), 32'(done_comb), 32'd1);
        check($sformatf("p%0d_busy", k), 32'(busy), 32'd1);
        check($sformatf("p%0d_stream_row", k), 32'(stream_row), 32'(k));
        for (int c = 0; c < 3; c++) begin
            check($sformatf("p%0d_data_c%0d", k, c), 32'(fm_wm_adj_out[c]), 32'(mdl[k][c]));
        end
    endtask

    task automatic finish_pass(input string tag);
        check({tag, "_wd_done_comb"}, 32'(done_comb), 32'd0);
        check({tag, "_wd_busy"}, 32'(busy), 32'd1);
        check({tag, "_wd_row0"}, 32'(fm_wm_adj_out[0]), 32'(mdl[0][0]));
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_done_comb"}, 32'(done_comb), 32'd0);
    endtask

    initial begin
        int base;
        errors   = 0;
        checks   = 0;
        dc_count = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_row   = '0;
        wr_col   = '0;
        wr_data  = '0;
        start    = 1'b0;
        loopback = 1'b0;
        man_done = 1'b0;
        sync_ovr = 1'b0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 3; c++) mdl[r][c] = 16'd0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_done_comb", 32'(done_comb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        check("rst_stream_row", 32'(stream_row), 32'd0);
        check("rst_data_c2", 32'(fm_wm_adj_out[2]), 32'd0);

        // Basic pass with a held WAIT_DONE
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 3; c++) wr(r, c, 16'(10 * r + c), 1'b1);
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            check_row(k);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            check("hold_done_comb", 32'(done_comb), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
            tick();
        end
        finish_pass("basic");

        // Dropped writes: out of range in IDLE, in range during STREAM
        wr(6, 0, 16'hFFFF, 1'b0);
        wr(0, 3, 16'hFFFF, 1'b0);
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            check_row(k);
            wr_en   = (k == 1);
            wr_row  = 3'd2;
            wr_col  = 2'd1;
            wr_data = 16'h1234;
            tick();
        end
        wr_en = 1'b0;
        finish_pass("drop");

        // Start ignored while busy
        base = dc_count;
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            check_row(k);
            start = (k == 3);
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_wd_done_comb", 32'(done_comb), 32'd0);
        check("ign_wd_busy", 32'(busy), 32'd1);
        finish_pass("ign");
        for (int i = 0; i < 3; i++) tick();
        check("ign_no_restart", 32'(done_comb), 32'd0);
        check("ign_burst_len", 32'(dc_count - base), 32'd6);

        // Mid-stream reset clears state and buffer
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            check_row(k);
            if (k == 2) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        check("mrst_done_comb", 32'(done_comb), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_stream_row", 32'(stream_row), 32'd0);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 3; c++) mdl[r][c] = 16'd0;
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            check_row(k);
            tick();
        end
        finish_pass("mrst");

        // Back-to-back with the consumer's done looped back
        loopback = 1'b1;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 3; c++) wr(r, c, 16'(100 + 10 * r + c), 1'b1);
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            check_row(k);
            tick();
        end
        check("b2b_gap_done_comb", 32'(done_comb), 32'd0);
        check("b2b_gap_busy", 32'(busy), 32'd1);
        tick();
        check("b2b_idle_busy", 32'(busy), 32'd0);
        wr_en   = 1'b1;
        wr_row  = 3'd0;
        wr_col  = 2'd0;
        wr_data = 16'h0BEE;
        start   = 1'b1;
        tick();
        wr_en   = 1'b0;
        start   = 1'b0;
        mdl[0][0] = 16'h0BEE;
        for (int k = 0; k < 6; k++) begin
            check_row(k);
            tick();
        end
        check("b2b2_gap_done_comb", 32'(done_comb), 32'd0);
        tick();
        check("b2b2_idle_busy", 32'(busy), 32'd0);
        loopback = 1'b0;

        // Row sync check
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            check_row(k);
            check($sformatf("sync_p%0d", k), 32'(sync_err), (k >= 3) ? 32'(SYNC_ON) : 32'd0);
            sync_ovr = (k == 2);
            tick();
        end
        sync_ovr = 1'b0;
        check("sync_wd", 32'(sync_err), 32'(SYNC_ON));
        finish_pass("sync");
        check("sync_idle", 32'(sync_err), 32'(SYNC_ON));
        pulse_start();
        check("sync_cleared", 32'(sync_err), 32'd0);
        for (int k = 0; k < 6; k++) begin
            check_row(k);
            tick();
        end
        finish_pass("sync2");
        check("sync_final", 32'(sync_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
